// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling, held byte with valid/ack handshake.
// Latency: rx_valid rises 2 + DIV/2 + 9*DIV + 1 cycles after the rx falling edge; a byte completing while unread is dropped and flagged on overrun.
module uart_rx #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          rx_meta, rx_sync, rx_prev;
    logic          fall, byte_done, stop_bad;

    // Synchronizer idles high so reset release on an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = !rx_sync && rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_done   = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    if (rx_sync) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        cnt_nxt     = '0;
                        bit_idx_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_sync, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    state_nxt = IDLE;
                    if (rx_sync) begin
                        byte_done = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An ack in the completion cycle frees the holding register for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (byte_done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                    overrun  <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: DIV=8 and DIV=434 instances driven with serial frames, checked against a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx8 = 1'b1, ack8 = 1'b0, rxb = 1'b1, ackb = 1'b0;
    logic [7:0] d8, db;
    logic       v8, fe8, ov8, bz8, vb, feb, ovb, bzb;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_data;
    logic       m_valid, m_ovr;

    always #10 clk = ~clk;

    uart_rx #(.DIV(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx(rx8), .rx_ack(ack8),
        .rx_data(d8), .rx_valid(v8), .frame_err(fe8), .overrun(ov8), .busy(bz8)
    );

    uart_rx #(.DIV(434)) dutb (
        .clk(clk), .rst_n(rst_n), .rx(rxb), .rx_ack(ackb),
        .rx_data(db), .rx_valid(vb), .frame_err(feb), .overrun(ovb), .busy(bzb)
    );

    // Iteration c starts just after clock edge c (rx falls after edge 0) and samples at the following negedge.
    task automatic send_frame(input bit big, input logic [7:0] b, input logic stop, input int ack_cyc,
                              input int tail, output int rise_cyc, output int ferr_cnt);
        int         div;
        logic [9:0] fr;
        logic       bitv, v, prev_v;
        div      = big ? 434 : 8;
        fr       = {stop, b, 1'b0};
        rise_cyc = -1;
        ferr_cnt = 0;
        prev_v   = big ? vb : v8;
        for (int c = 0; c < 10 * div + tail; c++) begin
            @(posedge clk);
            #1;
            bitv = (c < 10 * div) ? fr[c / div] : 1'b1;
            if (big) begin
                rxb  = bitv;
                ackb = (c == ack_cyc);
            end else begin
                rx8  = bitv;
                ack8 = (c == ack_cyc);
            end
            @(negedge clk);
            v = big ? vb : v8;
            if (v && !prev_v && rise_cyc < 0) rise_cyc = c;
            prev_v = v;
            if (big ? feb : fe8) ferr_cnt++;
        end
        ack8 = 1'b0;
        ackb = 1'b0;
    endtask

    // Frame-level reference: what a completed frame does to the held byte.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_in_cycle);
        if (stop) begin
            if (!m_valid || ack_in_cycle) begin
                m_data  = b;
                m_valid = 1'b1;
                m_ovr   = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic pulse_ack8();
        @(posedge clk);
        #1 ack8 = 1'b1;
        @(posedge clk);
        #1 ack8 = 1'b0;
        @(negedge clk);
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", d8); end
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v8); end
        checks++; if (fe8 !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", fe8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", ov8); end
        checks++; if (bz8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bz8); end
        checks++; if ({db, vb, feb, ovb, bzb} !== 12'h000) begin errors++; $display("FAIL reset_big got %h exp 000", {db, vb, feb, ovb, bzb}); end
        #1 rst_n = 1'b1;
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_glitch();
        int last_busy, fe_seen, v_seen;
        bit saw_busy;
        last_busy = -1; fe_seen = 0; v_seen = 0; saw_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 rx8 = (c < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bz8) begin saw_busy = 1; last_busy = c; end
            if (fe8) fe_seen++;
            if (v8) v_seen++;
        end
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_detect got %b exp 1", saw_busy); end
        checks++; if (last_busy > 9) begin errors++; $display("FAIL glitch_busy_end got %0d exp <=9", last_busy); end
        checks++; if (fe_seen != 0) begin errors++; $display("FAIL glitch_ferr got %0d exp 0", fe_seen); end
        checks++; if (v_seen != 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", v_seen); end
    endtask

    task automatic test_frame_err();
        int rise, ferr;
        send_frame(0, 8'h3C, 1'b0, -1, 6, rise, ferr);
        model_frame(8'h3C, 1'b0, 1'b0);
        checks++; if (ferr != 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", ferr); end
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b exp 0", v8); end
        checks++; if (d8 !== m_data) begin errors++; $display("FAIL ferr_data got %h exp %h", d8, m_data); end
    endtask

    task automatic test_basic();
        int rise, ferr;
        send_frame(0, 8'hA5, 1'b1, -1, 4, rise, ferr);
        model_frame(8'hA5, 1'b1, 1'b0);
        checks++; if (rise < 78 || rise > 80) begin errors++; $display("FAIL basic_latency got %0d exp 79+-1", rise); end
        checks++; if (d8 !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", d8); end
        checks++; if (ferr != 0) begin errors++; $display("FAIL basic_ferr got %0d exp 0", ferr); end
        checks++; if (bz8 !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", bz8); end
        pulse_ack8();
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL basic_ack got %b exp 0", v8); end
        checks++; if (d8 !== 8'hA5) begin errors++; $display("FAIL basic_hold got %h exp a5", d8); end
    endtask

    task automatic test_overrun();
        int rise, ferr;
        send_frame(0, 8'h11, 1'b1, -1, 0, rise, ferr);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b1, -1, 4, rise, ferr);
        model_frame(8'h22, 1'b1, 1'b0);
        checks++; if (d8 !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", d8); end
        checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", ov8); end
        checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", v8); end
        pulse_ack8();
        checks++; if ({v8, ov8} !== 2'b00) begin errors++; $display("FAIL ovr_ack got %b exp 00", {v8, ov8}); end
    endtask

    task automatic test_back_to_back_ack();
        int rise, ferr;
        send_frame(0, 8'h55, 1'b1, -1, 0, rise, ferr);
        model_frame(8'h55, 1'b1, 1'b0);
        checks++; if (d8 !== 8'h55) begin errors++; $display("FAIL b2b_first got %h exp 55", d8); end
        send_frame(0, 8'h66, 1'b1, 78, 4, rise, ferr);
        model_frame(8'h66, 1'b1, 1'b1);
        checks++; if (d8 !== 8'h66) begin errors++; $display("FAIL b2b_data got %h exp 66", d8); end
        checks++; if ({v8, ov8} !== 2'b10) begin errors++; $display("FAIL b2b_flags got %b exp 10", {v8, ov8}); end
        pulse_ack8();
    endtask

    task automatic test_random();
        int rise, ferr;
        logic [7:0] b;
        logic stop;
        for (int n = 0; n < 16; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(0, b, stop, -1, 4, rise, ferr);
            model_frame(b, stop, 1'b0);
            checks++; if (ferr != (stop ? 0 : 1)) begin errors++; $display("FAIL rand_ferr n=%0d got %0d exp %0d", n, ferr, stop ? 0 : 1); end
            checks++; if ({d8, v8, ov8} !== {m_data, m_valid, m_ovr}) begin
                errors++; $display("FAIL rand_state n=%0d got %h/%b/%b exp %h/%b/%b", n, d8, v8, ov8, m_data, m_valid, m_ovr);
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack8();
                checks++; if ({v8, ov8} !== {m_valid, m_ovr}) begin errors++; $display("FAIL rand_ack n=%0d got %b exp %b", n, {v8, ov8}, {m_valid, m_ovr}); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int rise, ferr;
        logic [9:0] fr;
        fr = {1'b1, 8'h00, 1'b0};
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1 rxb = fr[c / 434];
        end
        @(negedge clk);
        checks++; if (bzb !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", bzb); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        rxb = 1'b1;
        @(negedge clk);
        checks++; if ({db, vb, feb, ovb, bzb} !== 12'h000) begin errors++; $display("FAIL midrst_in_reset got %h exp 000", {db, vb, feb, ovb, bzb}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (bzb !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b exp 0", bzb); end
        send_frame(1, 8'hC3, 1'b1, -1, 4, rise, ferr);
        checks++; if (rise < 4125 || rise > 4127) begin errors++; $display("FAIL big_latency got %0d exp 4126+-1", rise); end
        checks++; if ({db, vb, ovb} !== {8'hC3, 1'b1, 1'b0}) begin errors++; $display("FAIL big_data got %h/%b/%b exp c3/1/0", db, vb, ovb); end
        checks++; if (ferr != 0) begin errors++; $display("FAIL big_ferr got %0d exp 0", ferr); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_frame_err();
        test_basic();
        test_overrun();
        test_back_to_back_ack();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first; the receive-side counterpart of the hub's uart_tx.
- Recovers bytes from an asynchronous serial line and presents them on a held output with valid/ack handshake.
- Flags framing errors and overruns.
- Sits in tt_um_sensor_hub_top on a ui_in pin. It will feed a command decoder that configures the pacing and ADC path.

Parameters:
- DIV, 434, clk cycles per bit (50 MHz / 115200). Legal range DIV >= 4. Counter width is $clog2(DIV).

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, asynchronous to clk, idle high
- rx_ack  input  1  consumer ack; clears rx_valid and overrun
- rx_data  output  8  last accepted byte; held until the next accepted byte
- rx_valid  output  1  level; high while rx_data is unread
- frame_err  output  1  one-cycle pulse on a bad stop bit
- overrun  output  1  sticky; a byte completed while rx_valid was high and not acked
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - State = IDLE.
  - Synchronizer flops = 1.
  - Reset is effective mid-frame and discards any partial byte.
- Input path:
  - 2-flop synchronizer on rx, then one extra registered copy used for edge detection.
  - Falling edge = synced 0 and previous 1.
  - Edge is detected 2 cycles after rx falls.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - On a falling edge, go to START and clear the counter.
  - A line held low (break, or after a frame error) produces no edge, so no new frame starts until the line returns high.
- START:
  - Sample the synced line when the counter reaches DIV/2-1, i.e. mid start bit.
  - If the sample is 1: false start (glitch), return to IDLE with no outputs.
  - If the sample is 0: go to DATA, clear the counter and the bit index.
- DATA:
  - Sample each bit every DIV cycles, i.e. at counter = DIV-1, mid-bit.
  - Shift into the shift register LSB first.
  - After bit index 7, go to STOP.
- STOP:
  - Sample after DIV cycles.
  - Sample 1: byte complete; go to IDLE in the same cycle.
  - Sample 0: frame_err pulses for 1 cycle; the byte is discarded (rx_data, rx_valid and overrun unchanged); go to IDLE.
- Byte-complete handling, registered so outputs change on the next cycle:
  - rx_valid = 0: load rx_data, set rx_valid.
  - rx_valid = 1 with rx_ack in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid = 1 without rx_ack: keep the old rx_data, drop the new byte, set overrun.
- rx_ack:
  - With rx_valid = 1 and no completion: clear rx_valid and overrun on the next cycle.
  - rx_ack while rx_valid = 0 is ignored.
- Latency: rx_valid rises 2 + DIV/2 + 9*DIV + 1 cycles after the rx falling edge, with ±1 cycle of phase uncertainty.
- Back-to-back frames:
  - The next start edge is accepted from IDLE immediately after the stop sample.
  - This gives a half-bit margin for DIV clock mismatch up to ±4%.

Test Plan:
- DIV=8, send 0xA5 (frame 0,1,0,1,0,0,1,0,1,1) -> rx_valid high at cycle 79±1 after the start edge, rx_data=0xA5, frame_err=0; assert rx_ack -> rx_valid=0 next cycle.
- DIV=8, 2-cycle low glitch on idle rx -> no rx_valid, no frame_err, busy returns to 0 within DIV/2+3 cycles.
- DIV=8, send 0x3C with the stop bit driven 0, then the line high -> one frame_err pulse, rx_valid stays 0, rx_data unchanged (0x00).
- DIV=8, send 0x11 then 0x22 back-to-back with no ack -> rx_data=0x11, overrun=1; rx_ack -> rx_valid=0, overrun=0.
- DIV=8, send 0x55 then 0x66, pulsing rx_ack in exactly the completion cycle of 0x66 -> rx_data=0x66, rx_valid=1, overrun=0.
- DIV=434, mid-frame rst_n pulse, then a clean 0xC3 frame -> outputs at reset values during reset, then 0xC3 received correctly.
